// File: rtl/mips_pkg.sv
// Shared MIPS encodings: opcodes, functs, ALU op codes, control states and the
// per-state control word of the multicycle controller.
package mips_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;

   localparam logic [5:0] F_ADD = 6'b100000;
   localparam logic [5:0] F_SUB = 6'b100010;
   localparam logic [5:0] F_AND = 6'b100100;
   localparam logic [5:0] F_OR  = 6'b100101;
   localparam logic [5:0] F_SLT = 6'b101010;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

   localparam logic [1:0] SRCB_B      = 2'b00;
   localparam logic [1:0] SRCB_4      = 2'b01;
   localparam logic [1:0] SRCB_IMM    = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXEC   = 4'd6,  S_ALUWB  = 4'd7,
      S_BRANCH = 4'd8,  S_JUMP   = 4'd9,  S_ADDIEX = 4'd10, S_ADDIWB = 4'd11
   } state_t;

   typedef struct packed {
      logic       pc_write;
      logic       branch;
      logic       iord;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       mem_to_reg;
      logic       reg_dst;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] pc_source;
      logic [2:0] alu_op;
      logic       instr_done;
   } ctrl_t;

   function automatic ctrl_t state_ctrl(input state_t s, input logic [2:0] exec_op);
      ctrl_t c;
      c = '0;
      case (s)
         S_FETCH: begin
            c.mem_read = 1'b1; c.ir_write = 1'b1; c.alu_src_b = SRCB_4;
            c.alu_op = ALU_ADD; c.pc_write = 1'b1; c.pc_source = PCSRC_ALU;
         end
         S_DECODE: begin c.alu_src_b = SRCB_IMM_SH; c.alu_op = ALU_ADD; end
         S_MEMADR, S_ADDIEX: begin
            c.alu_src_a = 1'b1; c.alu_src_b = SRCB_IMM; c.alu_op = ALU_ADD;
         end
         S_MEMRD: begin c.mem_read = 1'b1; c.iord = 1'b1; end
         S_MEMWB: begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; c.instr_done = 1'b1; end
         S_MEMWR: begin c.mem_write = 1'b1; c.iord = 1'b1; c.instr_done = 1'b1; end
         S_EXEC:  begin c.alu_src_a = 1'b1; c.alu_src_b = SRCB_B; c.alu_op = exec_op; end
         S_ALUWB: begin c.reg_write = 1'b1; c.reg_dst = 1'b1; c.instr_done = 1'b1; end
         S_BRANCH: begin
            c.alu_src_a = 1'b1; c.alu_src_b = SRCB_B; c.alu_op = ALU_SUB;
            c.pc_source = PCSRC_ALUOUT; c.branch = 1'b1; c.instr_done = 1'b1;
         end
         S_JUMP:   begin c.pc_write = 1'b1; c.pc_source = PCSRC_JUMP; c.instr_done = 1'b1; end
         S_ADDIWB: begin c.reg_write = 1'b1; c.instr_done = 1'b1; end
         default: ;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/mips_mc_control_if.sv
// Control-unit bundle: IR fields and zero flag in, datapath strobes/selects out.
interface mips_mc_control_if #(parameter int STATE_W = 4);
   logic [5:0]         opcode;
   logic [5:0]         funct;
   logic               zero;
   logic               pc_en;
   logic               iord;
   logic               mem_read;
   logic               mem_write;
   logic               ir_write;
   logic               mem_to_reg;
   logic               reg_dst;
   logic               reg_write;
   logic               alu_src_a;
   logic [1:0]         alu_src_b;
   logic [1:0]         pc_source;
   logic [2:0]         alu_op;
   logic               instr_done;
   logic               illegal_op;
   logic [STATE_W-1:0] state;

   modport master (
      input  opcode, funct, zero,
      output pc_en, iord, mem_read, mem_write, ir_write, mem_to_reg, reg_dst,
             reg_write, alu_src_a, alu_src_b, pc_source, alu_op, instr_done,
             illegal_op, state
   );

   modport slave (
      output opcode, funct, zero,
      input  pc_en, iord, mem_read, mem_write, ir_write, mem_to_reg, reg_dst,
             reg_write, alu_src_a, alu_src_b, pc_source, alu_op, instr_done,
             illegal_op, state
   );
endinterface

// File: rtl/mips_alu_decoder.sv
// R-type funct to ALU op code, plus a flag for functs the ALU supports.
import mips_pkg::*;

module mips_alu_decoder (
   input  logic [5:0] funct,
   output logic [2:0] alu_op,
   output logic       funct_valid
);
   always_comb begin
      alu_op      = ALU_ADD;
      funct_valid = 1'b1;
      case (funct)
         F_ADD:   alu_op = ALU_ADD;
         F_SUB:   alu_op = ALU_SUB;
         F_AND:   alu_op = ALU_AND;
         F_OR:    alu_op = ALU_OR;
         F_SLT:   alu_op = ALU_SLT;
         default: funct_valid = 1'b0;
      endcase
   end
endmodule

// File: rtl/mips_mc_control.sv
// Multicycle MIPS main control FSM; the control word is registered from the
// next state, and reset gates every output to zero.
import mips_pkg::*;

module mips_mc_control #(
   parameter int STATE_W     = 4,
   parameter bit ENABLE_ADDI = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   mips_mc_control_if.master bus
);
   state_t     st, nxt;
   ctrl_t      ctl_q, ctl;
   logic [2:0] dec_op;
   logic       funct_valid;
   logic       legal;

   mips_alu_decoder u_dec (
      .funct       (bus.funct),
      .alu_op      (dec_op),
      .funct_valid (funct_valid)
   );

   always_comb begin
      nxt   = S_FETCH;
      legal = 1'b1;
      case (st)
         S_FETCH:  nxt = S_DECODE;
         S_DECODE: begin
            case (bus.opcode)
               OP_LW, OP_SW: nxt = S_MEMADR;
               OP_RTYPE: if (funct_valid) nxt = S_EXEC; else legal = 1'b0;
               OP_BEQ:   nxt = S_BRANCH;
               OP_J:     nxt = S_JUMP;
               OP_ADDI:  if (ENABLE_ADDI) nxt = S_ADDIEX; else legal = 1'b0;
               default:  legal = 1'b0;
            endcase
         end
         S_MEMADR: nxt = (bus.opcode == OP_LW) ? S_MEMRD : S_MEMWR;
         S_MEMRD:  nxt = S_MEMWB;
         S_EXEC:   nxt = S_ALUWB;
         S_ADDIEX: nxt = S_ADDIWB;
         default:  nxt = S_FETCH;
      endcase
   end

   // funct is stable in DECODE, so the EXEC alu_op can be captured on entry.
   always_ff @(posedge clk) begin
      if (reset) begin
         st    <= S_FETCH;
         ctl_q <= state_ctrl(S_FETCH, ALU_ADD);
      end else begin
         st    <= nxt;
         ctl_q <= state_ctrl(nxt, dec_op);
      end
   end

   assign ctl = reset ? '0 : ctl_q;

   assign bus.pc_en      = ctl.pc_write | (ctl.branch & bus.zero);
   assign bus.iord       = ctl.iord;
   assign bus.mem_read   = ctl.mem_read;
   assign bus.mem_write  = ctl.mem_write;
   assign bus.ir_write   = ctl.ir_write;
   assign bus.mem_to_reg = ctl.mem_to_reg;
   assign bus.reg_dst    = ctl.reg_dst;
   assign bus.reg_write  = ctl.reg_write;
   assign bus.alu_src_a  = ctl.alu_src_a;
   assign bus.alu_src_b  = ctl.alu_src_b;
   assign bus.pc_source  = ctl.pc_source;
   assign bus.alu_op     = ctl.alu_op;
   assign bus.instr_done = ctl.instr_done;
   // Opcode only becomes valid in DECODE, so this pulse cannot be registered.
   assign bus.illegal_op = ~reset & (st == S_DECODE) & ~legal;
   assign bus.state      = reset ? '0 : STATE_W'(st);
endmodule

// File: tb/tb_mips_mc_control.sv
// Scoreboard bench: the driver queues per-cycle expected outputs, a negedge
// monitor pops and compares against both controllers (addi on and off).
import mips_pkg::*;

module tb_mips_mc_control;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   mips_mc_control_if #(.STATE_W(4)) bus ();
   mips_mc_control_if #(.STATE_W(4)) bus2 ();

   mips_mc_control #(.STATE_W(4), .ENABLE_ADDI(1'b1)) dut (.clk(clk), .reset(reset), .bus(bus));
   mips_mc_control #(.STATE_W(4), .ENABLE_ADDI(1'b0)) dut2 (.clk(clk), .reset(reset), .bus(bus2));

   assign bus2.opcode = bus.opcode;
   assign bus2.funct  = bus.funct;
   assign bus2.zero   = bus.zero;

   typedef struct {
      logic [21:0] v;
      bit          chk2;
      logic [4:0]  v2;
      string       nm;
   } exp_t;

   exp_t q[$];
   exp_t mon_e;
   int   tests = 0;
   int   fails = 0;

   // {state, pc_en, iord, mem_read, mem_write, ir_write, mem_to_reg, reg_dst,
   //  reg_write, alu_src_a, alu_src_b, pc_source, alu_op, instr_done, illegal_op}
   function automatic logic [21:0] exp_v(input int s, input logic [2:0] xop,
                                         input logic z, input logic ill);
      case (s)
         0:  return {4'd0,  9'b1_0_1_0_1_0_0_0_0, 2'b01, 2'b00, 3'b010, 2'b00};
         1:  return {4'd1,  9'b0, 2'b11, 2'b00, 3'b010, 1'b0, ill};
         2:  return {4'd2,  9'b0_0_0_0_0_0_0_0_1, 2'b10, 2'b00, 3'b010, 2'b00};
         3:  return {4'd3,  9'b0_1_1_0_0_0_0_0_0, 7'b0, 2'b00};
         4:  return {4'd4,  9'b0_0_0_0_0_1_0_1_0, 7'b0, 2'b10};
         5:  return {4'd5,  9'b0_1_0_1_0_0_0_0_0, 7'b0, 2'b10};
         6:  return {4'd6,  9'b0_0_0_0_0_0_0_0_1, 2'b00, 2'b00, xop, 2'b00};
         7:  return {4'd7,  9'b0_0_0_0_0_0_1_1_0, 7'b0, 2'b10};
         8:  return {4'd8,  z, 8'b0000_0001, 2'b00, 2'b01, 3'b110, 2'b10};
         9:  return {4'd9,  9'b1_0000_0000, 2'b00, 2'b10, 3'b000, 2'b10};
         10: return {4'd10, 9'b0_0000_0001, 2'b10, 2'b00, 3'b010, 2'b00};
         11: return {4'd11, 9'b0_0000_0010, 7'b0, 2'b10};
         default: return 22'b0;
      endcase
   endfunction

   task automatic step(input logic r, input logic [5:0] op, input logic [5:0] fn,
                       input logic z, input int s, input logic [2:0] xop,
                       input logic ill, input bit chk2, input logic [4:0] v2,
                       input string nm);
      exp_t e;
      @(posedge clk);
      #1;
      reset      = r;
      bus.opcode = op;
      bus.funct  = fn;
      bus.zero   = z;
      e.v    = exp_v(s, xop, z, ill);
      e.chk2 = chk2;
      e.v2   = v2;
      e.nm   = nm;
      q.push_back(e);
   endtask

   task automatic run(input string nm, input logic [5:0] op, input logic [5:0] fn,
                      input logic z, input int n, input int seq[6],
                      input logic [2:0] xop, input logic ill);
      for (int i = 0; i < n; i++)
         step(1'b0, op, fn, z, seq[i], xop, (seq[i] == 1) ? ill : 1'b0, 1'b0, 5'd0, nm);
   endtask

   always @(negedge clk) begin
      if (q.size() > 0) begin
         mon_e = q.pop_front();
         tests++;
         if ({bus.state, bus.pc_en, bus.iord, bus.mem_read, bus.mem_write, bus.ir_write,
              bus.mem_to_reg, bus.reg_dst, bus.reg_write, bus.alu_src_a, bus.alu_src_b,
              bus.pc_source, bus.alu_op, bus.instr_done, bus.illegal_op} !== mon_e.v) begin
            fails++;
            $display("FAIL %s: got %b want %b", mon_e.nm,
                     {bus.state, bus.pc_en, bus.iord, bus.mem_read, bus.mem_write,
                      bus.ir_write, bus.mem_to_reg, bus.reg_dst, bus.reg_write,
                      bus.alu_src_a, bus.alu_src_b, bus.pc_source, bus.alu_op,
                      bus.instr_done, bus.illegal_op}, mon_e.v);
         end
         if (mon_e.chk2) begin
            tests++;
            if ({bus2.state, bus2.illegal_op} !== mon_e.v2) begin
               fails++;
               $display("FAIL %s/noaddi: got %b want %b", mon_e.nm,
                        {bus2.state, bus2.illegal_op}, mon_e.v2);
            end
         end
      end
   end

   initial begin
      reset      = 1'b1;
      bus.opcode = 6'd0;
      bus.funct  = 6'd0;
      bus.zero   = 1'b0;
      repeat (3) step(1'b1, OP_LW, 6'd0, 1'b0, -1, 3'd0, 1'b0, 1'b1, 5'd0, "reset");

      run("lw",      OP_LW,    6'd0,  1'b0, 5, '{0,1,2,3,4,0}, 3'd0,    1'b0);
      run("r_sub",   OP_RTYPE, F_SUB, 1'b0, 4, '{0,1,6,7,0,0}, ALU_SUB, 1'b0);
      run("r_slt",   OP_RTYPE, F_SLT, 1'b1, 4, '{0,1,6,7,0,0}, ALU_SLT, 1'b0);
      run("r_or",    OP_RTYPE, F_OR,  1'b0, 4, '{0,1,6,7,0,0}, ALU_OR,  1'b0);
      run("beq_z1",  OP_BEQ,   6'd0,  1'b1, 3, '{0,1,8,0,0,0}, 3'd0,    1'b0);
      run("beq_z0",  OP_BEQ,   6'd0,  1'b0, 3, '{0,1,8,0,0,0}, 3'd0,    1'b0);
      run("sw",      OP_SW,    6'd0,  1'b0, 4, '{0,1,2,5,0,0}, 3'd0,    1'b0);
      run("j",       OP_J,     6'd0,  1'b1, 3, '{0,1,9,0,0,0}, 3'd0,    1'b0);
      run("ill_op",  6'b111111, 6'd0, 1'b0, 2, '{0,1,0,0,0,0}, 3'd0,    1'b1);
      run("ill_fn",  OP_RTYPE, 6'd0,  1'b0, 2, '{0,1,0,0,0,0}, 3'd0,    1'b1);

      // addi: legal on dut, illegal in DECODE on the addi-disabled controller
      step(1'b0, OP_ADDI, 6'd0, 1'b0, 0,  3'd0, 1'b0, 1'b1, {4'd0, 1'b0}, "addi");
      step(1'b0, OP_ADDI, 6'd0, 1'b0, 1,  3'd0, 1'b0, 1'b1, {4'd1, 1'b1}, "addi");
      step(1'b0, OP_ADDI, 6'd0, 1'b0, 10, 3'd0, 1'b0, 1'b1, {4'd0, 1'b0}, "addi");
      step(1'b0, OP_ADDI, 6'd0, 1'b0, 11, 3'd0, 1'b0, 1'b0, 5'd0, "addi");

      run("lw2",     OP_LW,    6'd0,  1'b0, 5, '{0,1,2,3,4,0}, 3'd0,    1'b0);

      // reset lands in the MEMRD cycle: no strobes, then a clean FETCH
      run("lw_rst",  OP_LW,    6'd0,  1'b0, 3, '{0,1,2,0,0,0}, 3'd0,    1'b0);
      step(1'b1, OP_LW, 6'd0, 1'b0, -1, 3'd0, 1'b0, 1'b1, 5'd0, "lw_rst");
      step(1'b0, OP_LW, 6'd0, 1'b0, 0,  3'd0, 1'b0, 1'b1, {4'd0, 1'b0}, "lw_rst");
      run("after_rst", OP_J,   6'd0,  1'b0, 2, '{1,9,0,0,0,0}, 3'd0,    1'b0);

      repeat (3) @(negedge clk);
      if (q.size() != 0) begin
         fails++;
         $display("FAIL drain: got %0d pending want 0", q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
